counter_dispatch: RTL and testbench
===================================

Name: counter_dispatch

Overview:
- Consumer stage directly downstream of the customer FIFO.
- Owns N_CTR service counters (bank tellers). Pops one waiting customer {number, service time} per cycle into the lowest-indexed idle counter.
- Each busy counter counts its customer's service time down on the global time tick, then pulses done and frees itself.
- Feeds display/statistics logic with per-counter status and a served-customer total.

Parameters:
- DT_SZ, 4, width of customer number and of service time.
- N_CTR, 2, number of service counters (1..8).
- SRV_W, 8, width of the served-customer total.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tick  in  1  one-cycle time-unit enable; countdowns advance only on tick.
- q_empty  in  1  FIFO empty flag.
- qn  in  DT_SZ  FIFO head customer number.
- qt  in  DT_SZ  FIFO head service time.
- q_re  out  1  FIFO read enable (pop).
- busy  out  N_CTR  bit k=1 while counter k is serving.
- cnum  out  N_CTR*DT_SZ  customer number at counter k, in slice [k*DT_SZ +: DT_SZ]; 0 when idle.
- crem  out  N_CTR*DT_SZ  remaining time at counter k, same slicing; 0 when idle.
- done  out  N_CTR  one-cycle pulse when counter k finishes a customer.
- served  out  SRV_W  total customers completed since reset.

Behaviour:
- Reset (async, rst_n=0): every counter goes to IDLE; busy, cnum, crem, done and served are 0. q_re is 0 because no counter is dispatchable during reset. Release takes effect on the first clk edge with rst_n=1.
- Per-counter FSM, two states:
  - IDLE: busy=0, cnum=0, crem=0.
  - SERVE: busy=1.
- q_re is combinational: q_re = !q_empty && (some counter is in IDLE). It is never asserted when q_empty=1.
- Dispatch: in any cycle where q_re=1, target = lowest index k in IDLE.
  - At that clk edge, counter k latches cnum<=qn and crem<=(qt==0 ? 1 : qt), then goes to SERVE. The FIFO advances on the same edge.
  - Only one dispatch per cycle, even if several counters are idle.
- Countdown: in SERVE with tick=1:
  - crem>1: crem<=crem-1.
  - crem==1: done[k]<=1 for exactly one cycle, counter goes to IDLE (cnum, crem <=0), served increments.
- tick=0: no countdown; dispatch is still permitted.
- Tick in the load cycle does not decrement the new customer: the counter was IDLE at that edge.
- Back-to-back service: a counter that completes at edge t is IDLE in cycle t+1 and may be reloaded at edge t+1, a one-cycle gap. No same-edge finish-and-reload.
- Service latency: a customer loaded with time T (T>=1) sees done exactly at the T-th tick edge after load.
- Simultaneous completions: several done bits may pulse in the same cycle; served adds popcount(done).
- served saturates at 2^SRV_W-1 and never wraps.
- qn/qt are sampled only when q_re=1; their contents are don't-care otherwise.
- Reset mid-service aborts all customers immediately. No done pulse is issued and served returns to 0.

Decomposition:
- Shared package holds:
  - DT_SZ default.
  - FSM state encoding (ST_IDLE=1'b0, ST_SERVE=1'b1).
  - A helper for the min-1 service-time clamp.
- One sub-module, service_counter: single-counter FSM with load/tick inputs and busy/num/rem/done outputs.
- counter_dispatch instantiates N_CTR copies via generate and contains:
  - priority-select logic for the dispatch target;
  - q_re generation;
  - the saturating popcount accumulator for served.

Test Plan:
1. Assert rst_n=0 with q_empty=0 -> q_re=0, busy=0, cnum=crem=0, done=0, served=0. Release -> q_re=1 in the first cycle.
2. q_empty=0, qn=5, qt=3, tick every cycle, N_CTR=2 -> one dispatch, busy=2'b01, cnum[0]=5, crem[0]=3,2,1. done[0] pulses on the 3rd tick edge, then busy=0 and served=1.
3. Two customers queued (7,2) then (9,4), both counters idle -> q_re high two consecutive cycles. Counter0 gets 7, counter1 gets 9 one cycle later. done[0] precedes done[1] by 3 cycles, and served ends at 2.
4. Both counters busy with q_empty=0 -> q_re=0 until a done pulse. q_re=1 in the cycle after done, and the freed counter loads the next head.
5. qt=0 with customer 3 -> crem loads 1, and done pulses on the next tick edge. tick held low for 5 cycles -> crem frozen at 1 with no done.
6. rst_n driven low while counter0 has crem=2 -> outputs clear asynchronously and no done pulse is seen. After release, dispatch resumes from the current FIFO head.

Source files
------------

// File: rtl/counter_dispatch_pkg.sv
// rtl/counter_dispatch_pkg.sv - shared constants and helpers for the counter dispatch stage
package counter_dispatch_pkg;

  localparam int DT_SZ_DEF = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  // A zero service time would never finish; treat it as one time unit.
  function automatic logic [31:0] clamp_min1(input logic [31:0] t);
    return (t == 32'd0) ? 32'd1 : t;
  endfunction

endpackage

// File: rtl/counter_dispatch_service_counter.sv
// rtl/counter_dispatch_service_counter.sv - one service counter: load, tick-driven countdown, done pulse
module service_counter
  import counter_dispatch_pkg::*;
#(
  parameter int DT_SZ = DT_SZ_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DT_SZ-1:0] load_num,
  input  logic [DT_SZ-1:0] load_time,
  input  logic             tick,
  output logic             busy,
  output logic [DT_SZ-1:0] num,
  output logic [DT_SZ-1:0] rem,
  output logic             done,
  output logic             fin
);

  logic [0:0]       state;
  logic [DT_SZ-1:0] num_q;
  logic [DT_SZ-1:0] rem_q;
  logic             done_q;

  // fin is the combinational "completes at this edge" used by the served total.
  assign fin  = (state == ST_SERVE) && tick && (rem_q == DT_SZ'(1));
  assign busy = (state == ST_SERVE);
  assign num  = num_q;
  assign rem  = rem_q;
  assign done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      num_q  <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            state <= ST_SERVE;
            num_q <= load_num;
            rem_q <= DT_SZ'(clamp_min1(32'(load_time)));
          end
        end
        default: begin
          if (tick) begin
            if (rem_q == DT_SZ'(1)) begin
              state  <= ST_IDLE;
              num_q  <= '0;
              rem_q  <= '0;
              done_q <= 1'b1;
            end else begin
              rem_q <= rem_q - DT_SZ'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/counter_dispatch.sv
// rtl/counter_dispatch.sv - pops FIFO customers into the lowest idle service counter and totals completions
module counter_dispatch
  import counter_dispatch_pkg::*;
#(
  parameter int DT_SZ = DT_SZ_DEF,
  parameter int N_CTR = 2,
  parameter int SRV_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   q_empty,
  input  logic [DT_SZ-1:0]       qn,
  input  logic [DT_SZ-1:0]       qt,
  output logic                   q_re,
  output logic [N_CTR-1:0]       busy,
  output logic [N_CTR*DT_SZ-1:0] cnum,
  output logic [N_CTR*DT_SZ-1:0] crem,
  output logic [N_CTR-1:0]       done,
  output logic [SRV_W-1:0]       served
);

  localparam int SUM_W = SRV_W + 4;
  localparam logic [SUM_W-1:0] SRV_MAX = SUM_W'({SRV_W{1'b1}});

  logic [N_CTR-1:0] idle;
  logic [N_CTR-1:0] sel;
  logic [N_CTR-1:0] load;
  logic [N_CTR-1:0] fin;
  logic [3:0]       fin_cnt;
  logic [SUM_W-1:0] sum;
  logic             found;

  assign idle = ~busy;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N_CTR; k++) begin
      if (idle[k] && !found) begin
        sel[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  // Counters all read idle while reset is held; gating keeps the FIFO from popping then.
  assign q_re = rst_n && !q_empty && (|idle);
  assign load = {N_CTR{q_re}} & sel;

  for (genvar g = 0; g < N_CTR; g++) begin : g_ctr
    service_counter #(.DT_SZ(DT_SZ)) u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[g]),
      .load_num (qn),
      .load_time(qt),
      .tick     (tick),
      .busy     (busy[g]),
      .num      (cnum[g*DT_SZ +: DT_SZ]),
      .rem      (crem[g*DT_SZ +: DT_SZ]),
      .done     (done[g]),
      .fin      (fin[g])
    );
  end

  always_comb begin
    fin_cnt = '0;
    for (int k = 0; k < N_CTR; k++) begin
      fin_cnt = fin_cnt + 4'(fin[k]);
    end
  end

  assign sum = SUM_W'(served) + SUM_W'(fin_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served <= '0;
    end else if (sum > SRV_MAX) begin
      served <= {SRV_W{1'b1}};
    end else begin
      served <= sum[SRV_W-1:0];
    end
  end

endmodule

// File: tb/tb_counter_dispatch.sv
// tb/tb_counter_dispatch.sv - randomized bench for counter_dispatch against a queue-based reference model
module tb_counter_dispatch;

  localparam int DT = 4;
  localparam int N  = 2;
  localparam int SW = 5;
  localparam int SRV_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick;
  logic          q_empty;
  logic [DT-1:0] qn, qt;
  logic          q_re;
  logic [N-1:0]  busy, done;
  logic [N*DT-1:0] cnum, crem;
  logic [SW-1:0] served;

  counter_dispatch #(.DT_SZ(DT), .N_CTR(N), .SRV_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .q_empty(q_empty), .qn(qn), .qt(qt),
    .q_re(q_re), .busy(busy), .cnum(cnum), .crem(crem), .done(done), .served(served)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [2*DT-1:0] fifo[$];
  bit m_busy[N];
  int m_num[N];
  int m_rem[N];
  bit m_done[N];
  int m_served;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic bit exp_qre();
    bit any_idle = 1'b0;
    for (int k = 0; k < N; k++) if (!m_busy[k]) any_idle = 1'b1;
    return rst_n && (fifo.size() != 0) && any_idle;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_busy[k] = 1'b0; m_num[k] = 0; m_rem[k] = 0; m_done[k] = 1'b0;
    end
    m_served = 0;
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_busy[k]));
      chk($sformatf("cnum[%0d]", k), 32'(cnum[k*DT +: DT]), 32'(m_num[k]));
      chk($sformatf("crem[%0d]", k), 32'(crem[k*DT +: DT]), 32'(m_rem[k]));
      chk($sformatf("done[%0d]", k), 32'(done[k]), 32'(m_done[k]));
    end
    chk("served", 32'(served), 32'(m_served));
    chk("q_re", 32'(q_re), 32'(exp_qre()));
  endtask

  // Reference behaviour for one clock edge, using the values present before it.
  task automatic advance();
    int tgt = -1;
    int fin = 0;
    logic [2*DT-1:0] e;
    if (!rst_n) return;
    if (exp_qre()) begin
      for (int k = 0; k < N; k++) if (!m_busy[k] && tgt < 0) tgt = k;
    end
    for (int k = 0; k < N; k++) begin
      m_done[k] = 1'b0;
      if (m_busy[k] && tick) begin
        if (m_rem[k] == 1) begin
          m_busy[k] = 1'b0; m_num[k] = 0; m_rem[k] = 0; m_done[k] = 1'b1; fin++;
        end else begin
          m_rem[k]--;
        end
      end
    end
    if (tgt >= 0) begin
      e = fifo.pop_front();
      m_busy[tgt] = 1'b1;
      m_num[tgt]  = int'(e[2*DT-1:DT]);
      m_rem[tgt]  = (e[DT-1:0] == '0) ? 1 : int'(e[DT-1:0]);
    end
    m_served = (m_served + fin > SRV_MAX) ? SRV_MAX : m_served + fin;
  endtask

  task automatic drive_head();
    q_empty = (fifo.size() == 0);
    if (fifo.size() != 0) {qn, qt} = fifo[0];
    else {qn, qt} = 2*DT'($urandom);
  endtask

  task automatic step(input bit tk);
    tick = tk;
    drive_head();
    #1;
    check_all();
    advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    step(1'b1);
    step(1'b1);
    rst_n = 1'b1;
  endtask

  task automatic push(input int n, input int t);
    fifo.push_back({DT'(n), DT'(t)});
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    model_clear();
    push(5, 3);
    drive_head();
    @(negedge clk);
    step(1'b1);
    step(1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1);

    push(7, 2); push(9, 4);
    for (int i = 0; i < 9; i++) step(1'b1);

    push(1, 5); push(2, 3); push(4, 6); push(6, 2);
    for (int i = 0; i < 20; i++) step(1'b1);

    push(3, 0);
    step(1'b0);
    for (int i = 0; i < 5; i++) step(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);

    push(1, 2); push(8, 3);
    step(1'b0);
    reset_pulse();
    for (int i = 0; i < 8; i++) step(1'b1);

    for (int i = 0; i < 1500; i++) begin
      if (fifo.size() < 6 && $urandom_range(0, 2) != 0)
        push(int'($urandom_range(0, 15)), int'($urandom_range(0, 6)));
      if ($urandom_range(0, 399) == 0) reset_pulse();
      step($urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
